// File: rtl/cpu_pkg.sv
// Shared decode-stage constants: register address width,
// producer latency codes and stall-source bit positions.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int LAT_W  = 3;

    localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W-1:0] LAT_CSR  = 3'd2;
    localparam logic [LAT_W-1:0] LAT_VAR  = 3'd7;

    localparam int SRC_RJ  = 0;
    localparam int SRC_RKD = 1;

endpackage

// File: rtl/sb_lat_cnt.sv
// Pending-latency counter for one architectural register.
// Ports: clk, resetn, flush, load/lat, clr, dec, cnt.
module sb_lat_cnt
    import cpu_pkg::*;
#(
    parameter int             W   = LAT_W,
    parameter logic [W-1:0]   VAR = LAT_VAR
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] lat,
    input  logic         clr,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    // Priority: flush > load > writeback clear > decrement.
    // VAR entries never decrement; only clr releases them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat;
        end else if (clr && cnt == VAR) begin
            cnt <= '0;
        end else if (dec && cnt != '0 && cnt != VAR) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard scoreboard: one latency counter per register.
// Ports: ds_* ID instruction, wb_clr*, flush, pipe_freeze; stall outputs.
module id_scoreboard #(
    parameter int                NUM_REGS = 32,
    parameter int                REG_AW   = cpu_pkg::REG_AW,
    parameter int                LAT_W    = cpu_pkg::LAT_W,
    parameter logic [LAT_W-1:0]  LAT_VAR  = '1,
    parameter int                PERF_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              pipe_freeze,
    input  logic              ds_valid,
    input  logic              ds_use_rj,
    input  logic              ds_use_rkd,
    input  logic [REG_AW-1:0] ds_rj,
    input  logic [REG_AW-1:0] ds_rkd,
    input  logic              ds_we,
    input  logic [REG_AW-1:0] ds_dest,
    input  logic [LAT_W-1:0]  ds_lat,
    input  logic              ds_issue,
    input  logic              wb_clr,
    input  logic [REG_AW-1:0] wb_clr_addr,
    output logic              stallreq_id,
    output logic [1:0]        stall_src,
    output logic              any_var_pending,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    // Table spans the full address space; slots for r0 and
    // addresses >= NUM_REGS are tied to zero, so any address
    // indexes safely and reads as not pending.
    localparam int NSLOT = 2 ** REG_AW;

    logic [LAT_W-1:0] cnt [NSLOT];
    logic             hz_rj;
    logic             hz_rkd;

    for (genvar r = 0; r < NSLOT; r++) begin : g_reg
        if (r == 0 || r >= NUM_REGS) begin : g_tie
            assign cnt[r] = '0;
        end else begin : g_cnt
            sb_lat_cnt #(
                .W   (LAT_W),
                .VAR (LAT_VAR)
            ) u_cnt (
                .clk    (clk),
                .resetn (resetn),
                .flush  (flush),
                .load   (ds_issue & ds_we &
                         (ds_dest == REG_AW'(r))),
                .lat    (ds_lat),
                .clr    (wb_clr &
                         (wb_clr_addr == REG_AW'(r))),
                .dec    (!pipe_freeze),
                .cnt    (cnt[r])
            );
        end
    end

    assign hz_rj  = ds_valid & ds_use_rj &
                    (ds_rj != '0) & (cnt[ds_rj] != '0);
    assign hz_rkd = ds_valid & ds_use_rkd &
                    (ds_rkd != '0) & (cnt[ds_rkd] != '0);

    assign stallreq_id = hz_rj | hz_rkd;

    always_comb begin
        stall_src = '0;
        stall_src[cpu_pkg::SRC_RJ]  = hz_rj;
        stall_src[cpu_pkg::SRC_RKD] = hz_rkd;
    end

    always_comb begin
        any_var_pending = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (cnt[i] == LAT_VAR) begin
                any_var_pending = 1'b1;
            end
        end
    end

    // Flush cycles are not counted; flush never clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_cnt <= '0;
        end else if (stallreq_id && !flush) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard.
// Drives after each rising edge, checks before the falling edge.
module tb_id_scoreboard;

    localparam logic [2:0] L_ALU  = 3'd0;
    localparam logic [2:0] L_LOAD = 3'd1;
    localparam logic [2:0] L_CSR  = 3'd2;
    localparam logic [2:0] L_VAR  = 3'd7;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        pipe_freeze;
    logic        ds_valid;
    logic        ds_use_rj;
    logic        ds_use_rkd;
    logic [4:0]  ds_rj;
    logic [4:0]  ds_rkd;
    logic        ds_we;
    logic [4:0]  ds_dest;
    logic [2:0]  ds_lat;
    logic        ds_issue;
    logic        wb_clr;
    logic [4:0]  wb_clr_addr;
    logic        stallreq_id;
    logic [1:0]  stall_src;
    logic        any_var_pending;
    logic [31:0] perf_stall_cnt;

    int checks;
    int errors;

    id_scoreboard dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .pipe_freeze     (pipe_freeze),
        .ds_valid        (ds_valid),
        .ds_use_rj       (ds_use_rj),
        .ds_use_rkd      (ds_use_rkd),
        .ds_rj           (ds_rj),
        .ds_rkd          (ds_rkd),
        .ds_we           (ds_we),
        .ds_dest         (ds_dest),
        .ds_lat          (ds_lat),
        .ds_issue        (ds_issue),
        .wb_clr          (wb_clr),
        .wb_clr_addr     (wb_clr_addr),
        .stallreq_id     (stallreq_id),
        .stall_src       (stall_src),
        .any_var_pending (any_var_pending),
        .perf_stall_cnt  (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic st,
                           input logic [1:0] src,
                           input logic vp);
        chk({tag, " stall"}, {31'd0, stallreq_id}, {31'd0, st});
        chk({tag, " src"}, {30'd0, stall_src}, {30'd0, src});
        chk({tag, " var"}, {31'd0, any_var_pending}, {31'd0, vp});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush       = 1'b0;
        pipe_freeze = 1'b0;
        ds_valid    = 1'b0;
        ds_use_rj   = 1'b0;
        ds_use_rkd  = 1'b0;
        ds_rj       = '0;
        ds_rkd      = '0;
        ds_we       = 1'b0;
        ds_dest     = '0;
        ds_lat      = '0;
        ds_issue    = 1'b0;
        wb_clr      = 1'b0;
        wb_clr_addr = '0;
    endtask

    task automatic issue(input logic [4:0] d,
                         input logic [2:0] l);
        idle();
        ds_valid = 1'b1;
        ds_issue = 1'b1;
        ds_we    = 1'b1;
        ds_dest  = d;
        ds_lat   = l;
    endtask

    task automatic use_rj(input logic [4:0] a);
        idle();
        ds_valid  = 1'b1;
        ds_use_rj = 1'b1;
        ds_rj     = a;
    endtask

    // Issuing an instruction that is being stalled is illegal.
    always @(negedge clk) begin
        if (resetn && ds_issue) begin
            chk("issue while stalled", {31'd0, stallreq_id}, 32'd0);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        idle();
        #3;
        chk_all("reset", 1'b0, 2'b00, 1'b0);
        chk("reset perf", perf_stall_cnt, 32'd0);
        step;
        step;
        resetn = 1'b1;
        step;

        // load r5, dependent one cycle later
        issue(5'd5, L_LOAD);
        #1 chk_all("ld issue", 1'b0, 2'b00, 1'b0);
        step;
        use_rj(5'd5);
        #1 chk_all("ld use", 1'b1, 2'b01, 1'b0);
        step;
        #1 chk_all("ld use+1", 1'b0, 2'b00, 1'b0);
        chk("ld perf", perf_stall_cnt, 32'd1);
        step;

        // ALU result never pends
        issue(5'd11, L_ALU);
        step;
        use_rj(5'd11);
        #1 chk_all("alu use", 1'b0, 2'b00, 1'b0);
        step;

        // CSR r7 with 3 frozen cycles
        issue(5'd7, L_CSR);
        #1 chk_all("csr issue", 1'b0, 2'b00, 1'b0);
        step;
        idle();
        ds_valid   = 1'b1;
        ds_use_rkd = 1'b1;
        ds_rkd     = 5'd7;
        for (int i = 0; i < 5; i++) begin
            pipe_freeze = (i < 3);
            #1 chk_all("csr wait", 1'b1, 2'b10, 1'b0);
            step;
        end
        pipe_freeze = 1'b0;
        #1 chk_all("csr done", 1'b0, 2'b00, 1'b0);
        chk("csr perf", perf_stall_cnt, 32'd6);
        step;

        // div r9 pending until writeback
        issue(5'd9, L_VAR);
        #1 chk_all("div issue", 1'b0, 2'b00, 1'b0);
        step;
        use_rj(5'd9);
        for (int i = 0; i < 20; i++) begin
            #1 chk_all("div wait", 1'b1, 2'b01, 1'b1);
            step;
        end
        wb_clr      = 1'b1;
        wb_clr_addr = 5'd9;
        #1 chk_all("div clr", 1'b1, 2'b01, 1'b1);
        step;
        wb_clr = 1'b0;
        #1 chk_all("div done", 1'b0, 2'b00, 1'b0);
        chk("div perf", perf_stall_cnt, 32'd27);
        step;

        // issue beats decrement and clear on r3
        issue(5'd3, L_CSR);
        step;
        idle();
        step;
        issue(5'd3, L_LOAD);
        wb_clr      = 1'b1;
        wb_clr_addr = 5'd3;
        #1 chk_all("iss+clr", 1'b0, 2'b00, 1'b0);
        step;
        use_rj(5'd3);
        #1 chk_all("iss wins", 1'b1, 2'b01, 1'b0);
        step;
        #1 chk_all("iss wins+1", 1'b0, 2'b00, 1'b0);
        step;

        // issue beats clear of a VAR entry
        issue(5'd3, L_VAR);
        step;
        issue(5'd3, L_LOAD);
        wb_clr      = 1'b1;
        wb_clr_addr = 5'd3;
        #1 chk_all("var iss", 1'b0, 2'b00, 1'b1);
        step;
        use_rj(5'd3);
        #1 chk_all("var iss use", 1'b1, 2'b01, 1'b0);
        step;
        #1 chk_all("var iss +1", 1'b0, 2'b00, 1'b0);
        chk("iss perf", perf_stall_cnt, 32'd29);
        step;

        // clear to a non-VAR entry is ignored
        issue(5'd12, L_CSR);
        step;
        use_rj(5'd12);
        wb_clr      = 1'b1;
        wb_clr_addr = 5'd12;
        #1 chk_all("clr ign", 1'b1, 2'b01, 1'b0);
        step;
        wb_clr = 1'b0;
        #1 chk_all("clr ign+1", 1'b1, 2'b01, 1'b0);
        step;
        #1 chk_all("clr ign+2", 1'b0, 2'b00, 1'b0);
        chk("clr perf", perf_stall_cnt, 32'd31);
        step;

        // flush with r4 VAR and r6 CSR
        issue(5'd4, L_VAR);
        step;
        issue(5'd6, L_CSR);
        step;
        idle();
        ds_valid   = 1'b1;
        ds_use_rj  = 1'b1;
        ds_rj      = 5'd4;
        ds_use_rkd = 1'b1;
        ds_rkd     = 5'd6;
        flush      = 1'b1;
        #1 chk_all("flush cyc", 1'b1, 2'b11, 1'b1);
        step;
        flush = 1'b0;
        #1 chk_all("post flush", 1'b0, 2'b00, 1'b0);
        chk("flush perf", perf_stall_cnt, 32'd31);
        step;

        // writes to r0 never pend
        issue(5'd0, L_CSR);
        step;
        idle();
        ds_valid   = 1'b1;
        ds_use_rj  = 1'b1;
        ds_use_rkd = 1'b1;
        #1 chk_all("r0 use", 1'b0, 2'b00, 1'b0);
        step;
        #1 chk_all("r0 use+1", 1'b0, 2'b00, 1'b0);
        step;

        // asynchronous reset mid-stall
        issue(5'd8, L_VAR);
        step;
        use_rj(5'd8);
        #1 chk_all("pre rst", 1'b1, 2'b01, 1'b1);
        step;
        chk("pre rst perf", perf_stall_cnt, 32'd32);
        #1 resetn = 1'b0;
        #1 chk_all("async rst", 1'b0, 2'b00, 1'b0);
        chk("async rst perf", perf_stall_cnt, 32'd0);
        step;
        step;
        resetn = 1'b1;
        step;
        #1 chk_all("after rst", 1'b0, 2'b00, 1'b0);
        chk("after rst perf", perf_stall_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised hazard unit for the decode stage. It replaces the fixed single-entry load/CSR hazard buffer.
- Holds one pending-latency counter per architectural register. Each counter is loaded when a producing instruction issues from ID.
- Requests an ID stall while any source operand of the instruction in ID is not yet forwardable.
- Supports variable-latency producers (mul/div) that are released only by writeback, a whole-table flush from the commit point, and a stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 never pending.
- REG_AW, 5, register address width; 2**REG_AW >= NUM_REGS.
- LAT_W, 3, counter width.
- LAT_VAR, 7 (all ones at LAT_W), latency code meaning "pending until writeback clear".
- PERF_W, 32, stall performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  commit-point flush; all younger work discarded.
- pipe_freeze  in  1  EX and later stages stalled; counters hold.
- ds_valid  in  1  ID holds a valid instruction.
- ds_use_rj  in  1  instruction reads rj.
- ds_use_rkd  in  1  instruction reads rk/rd.
- ds_rj  in  REG_AW  source 1 address.
- ds_rkd  in  REG_AW  source 2 address.
- ds_we  in  1  instruction writes a register.
- ds_dest  in  REG_AW  destination address.
- ds_lat  in  LAT_W  cycles until result forwardable: 0 = ALU, 1 = load, 2 = CSR, LAT_VAR = mul/div.
- ds_issue  in  1  instruction leaves ID this cycle.
- wb_clr  in  1  variable-latency result written back.
- wb_clr_addr  in  REG_AW  register released by writeback.
- stallreq_id  out  1  combinational stall request to the stall controller.
- stall_src  out  2  {rkd hazard, rj hazard}.
- any_var_pending  out  1  at least one LAT_VAR entry outstanding.
- perf_stall_cnt  out  PERF_W  cycles with stallreq_id = 1.

Behaviour:
- Reset (resetn = 0, asynchronous):
  - all counters = 0.
  - perf_stall_cnt = 0.
  - stallreq_id, stall_src and any_var_pending therefore evaluate to 0.
- Hazard detection (combinational, same cycle as inputs):
  - hz_rj = ds_valid & ds_use_rj & (ds_rj != 0) & (cnt[ds_rj] != 0).
  - hz_rkd is defined the same way on rkd.
  - stallreq_id = hz_rj | hz_rkd.
  - stall_src = {hz_rkd, hz_rj}.
  - No dependence on ds_issue, so there is no combinational loop.
- Counter update, per register r each cycle, first matching rule wins:
  1. flush: cnt = 0 for every r. Overrides issue and clear.
  2. ds_issue & ds_we & ds_dest == r & r != 0: cnt = ds_lat. Issue wins over same-cycle decrement or wb_clr on the same r.
  3. wb_clr & wb_clr_addr == r & cnt == LAT_VAR: cnt = 0. A clear to a non-LAT_VAR entry is ignored.
  4. !pipe_freeze & cnt != 0 & cnt != LAT_VAR: cnt = cnt - 1.
  5. Otherwise hold.
- Timing:
  - ds_lat = 0 never creates a pending entry (full forwarding).
  - A load issued in cycle t (lat 1) stalls a dependent instruction in cycle t+1 only.
  - pipe_freeze cycles extend the stall one-for-one.
- Writes to register 0 are ignored.
- ds_dest >= NUM_REGS is ignored. Source addresses >= NUM_REGS read as not pending.
- any_var_pending is the OR over all counters equal to LAT_VAR.
- perf_stall_cnt:
  - increments when stallreq_id = 1 and flush = 0.
  - wraps modulo 2**PERF_W.
  - is not cleared by flush.
- ds_issue while stallreq_id = 1 is illegal. The bench asserts it never happens.

Decomposition:
- Shared package, cpu_pkg:
  - REG_AW
  - latency codes LAT_ALU = 0, LAT_LOAD = 1, LAT_CSR = 2, LAT_VAR
  - stall_src bit positions
- One natural sub-module, sb_lat_cnt: a single-register counter with load, clear, decrement and flush priority. It is instantiated NUM_REGS-1 times via generate; register 0 is tied to 0.

Test Plan:
- Load r5 issued (lat 1), next cycle ds_rj = 5 with use_rj -> stallreq_id = 1 and stall_src = 2'b01 for exactly 1 cycle, then 0.
- CSR write r7 (lat 2) followed by a consumer of rkd = 7 with pipe_freeze high for 3 cycles in between -> stall held 5 cycles total; perf_stall_cnt advances by 5.
- Div to r9 (LAT_VAR), 20 idle cycles -> stall and any_var_pending stay 1; wb_clr with addr 9 -> both drop to 0 the next cycle.
- Same cycle: issue load to r3 (lat 1) while wb_clr addr 3 and the counter is decrementing -> cnt[3] = 1 after the edge (issue wins).
- flush with r4 at LAT_VAR and r6 at 2 -> all counters 0 next cycle; a consumer of r4/r6 is not stalled; perf_stall_cnt is unchanged.
- Writes to r0 with lat 2, a consumer of r0, and resetn pulsed low mid-stall -> no stall from r0; outputs are 0 immediately on resetn low, without waiting for a clock edge.
